pll_reset_sequencer: RTL

Controls the reset input of the fabric PLL and consumes its `locked` output, so that downstream clock domains leave reset only after the PLL is stably locked. The block runs on the 50 MHz PLL reference clock:
- It pulses the PLL reset, waits for lock and debounces it.
- It releases a fabric-wide reset request once lock is stable.
- It restarts the PLL on lock timeout, loss of lock or a software request.

Per-domain reset synchronizers in the 20/25/125 MHz domains consume `domain_rst`.

---
 rtl/pll_reset_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock debounce and fabric reset release on the refclk domain.
// Ports: refclk, rst_n, locked, restart in; pll_rst, domain_rst, ready, timeout_count, loss_count out.
// Optional lock statistics counters: define PLL_RESET_STATS_EN.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAT_W        = 8
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              restart,
  output logic              pll_rst,
  output logic              domain_rst,
  output logic              ready,
  output logic [STAT_W-1:0] timeout_count,
  output logic [STAT_W-1:0] loss_count
);

  localparam int MAX_A =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          sync1;
  logic          locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    if (restart) begin
      state_n = RESET_PLL;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) state_n = WAIT_LOCK;
          else                 cnt_n   = cnt + CW'(1);
        end
        WAIT_LOCK: begin
          if (locked_s)           state_n = STABILIZE;
          else if (cnt == TO_LAST) state_n = RESET_PLL;
          else                    cnt_n   = cnt + CW'(1);
        end
        STABILIZE: begin
          if (!locked_s)           state_n = WAIT_LOCK;
          else if (cnt == ST_LAST) state_n = RUN;
          else                     cnt_n   = cnt + CW'(1);
        end
        RUN: begin
          if (!locked_s) state_n = RESET_PLL;
        end
        default: state_n = RESET_PLL;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the
  // same edge as the transition.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_PLL;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pll_rst    <= (state_n == RESET_PLL);
      domain_rst <= (state_n != RUN);
      ready      <= (state_n == RUN);
    end
  end

`ifdef PLL_RESET_STATS_EN
  localparam logic [STAT_W-1:0] SAT = '1;

  logic tc_inc;
  logic lc_inc;

  assign tc_inc = !restart && (state == WAIT_LOCK)
                  && (state_n == RESET_PLL);
  assign lc_inc = !restart && (state == RUN)
                  && (state_n == RESET_PLL);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count <= '0;
      loss_count    <= '0;
    end else begin
      if (tc_inc && timeout_count != SAT)
        timeout_count <= timeout_count + STAT_W'(1);
      if (lc_inc && loss_count != SAT)
        loss_count <= loss_count + STAT_W'(1);
    end
  end
`else
  assign timeout_count = '0;
  assign loss_count    = '0;
`endif

endmodule
